// File: rtl/sd_frame_rx.sv
// Receive side of the sen/sd serial register-bank link: deserializes one
// address+data frame per sen-low window and issues a single-cycle bank write.
module sd_frame_rx #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 18,
   parameter int DEPTH     = 8,
   parameter int LAST_ADDR = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sen,
   input  logic              sd,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              done,
   output logic              frame_err,
   output logic              addr_err,
   output logic [7:0]        frame_cnt,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   localparam int FRAME_LEN = ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   localparam logic [CNT_W-1:0]  FRAME_LEN_C = CNT_W'(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_C      = ADDR_W'(LAST_ADDR);

   // IDLE: sen_q high. SHIFT: sen_q low. EVAL: the edge that saw sen rise.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      EVAL  = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [FRAME_LEN-1:0] shift_q;
   logic [ADDR_W-1:0]    frame_addr;
   logic [DATA_W-1:0]    frame_data;
   logic                 len_ok;
   logic                 addr_ok;

   assign frame_addr = shift_q[FRAME_LEN-1 -: ADDR_W];
   assign frame_data = shift_q[DATA_W-1:0];
   assign len_ok     = (bit_cnt == FRAME_LEN_C);
   assign addr_ok    = (32'(frame_addr) < DEPTH);
   assign state_dbg  = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_q   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         frame_cnt <= 8'd0;
         busy      <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         // done follows the write strobe by one cycle and is never cleared here
         if (wr_en && (wr_addr == LAST_C))
            done <= 1'b1;

         if (!en) begin
            // disabled: drop any partial frame silently
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
         end else if (!sen) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            shift_q <= {shift_q[FRAME_LEN-2:0], sd};
            if (bit_cnt != '1)
               bit_cnt <= bit_cnt + CNT_W'(1);
         end else begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            if (state == SHIFT) begin
               state <= EVAL;
               if (!len_ok) begin
                  frame_err <= 1'b1;
               end else if (!addr_ok) begin
                  addr_err <= 1'b1;
               end else begin
                  wr_en     <= 1'b1;
                  wr_addr   <= frame_addr;
                  wr_data   <= frame_data;
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end else begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_frame_rx.sv
// Bench for sd_frame_rx: a default instance and a DEPTH=5/LAST_ADDR=4 instance
// share one stimulus stream; a frame-level model predicts every output event.
module tb_sd_frame_rx;

   logic clk = 1'b0;
   logic rst, en, sen, sd;

   logic        wr_en_a, done_a, frame_err_a, addr_err_a, busy_a;
   logic [2:0]  wr_addr_a;
   logic [17:0] wr_data_a;
   logic [7:0]  frame_cnt_a;
   logic [1:0]  state_dbg_a;

   logic        wr_en_b, done_b, frame_err_b, addr_err_b, busy_b;
   logic [2:0]  wr_addr_b;
   logic [17:0] wr_data_b;
   logic [7:0]  frame_cnt_b;
   logic [1:0]  state_dbg_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // event = {kind, addr, data, cycle}; kind 0 write, 1 frame_err, 2 addr_err, 3 done rise
   logic [38:0] exp_qa[$];
   logic [38:0] exp_qb[$];
   logic [7:0]  cnt_m[2];
   logic        done_m[2];
   logic        pd_a = 1'b0;
   logic        pd_b = 1'b0;

   sd_frame_rx dut_a (
      .clk(clk), .rst(rst), .en(en), .sen(sen), .sd(sd),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .done(done_a), .frame_err(frame_err_a), .addr_err(addr_err_a),
      .frame_cnt(frame_cnt_a), .busy(busy_a), .state_dbg(state_dbg_a)
   );

   sd_frame_rx #(.DEPTH(5), .LAST_ADDR(4)) dut_b (
      .clk(clk), .rst(rst), .en(en), .sen(sen), .sd(sd),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .done(done_b), .frame_err(frame_err_b), .addr_err(addr_err_b),
      .frame_cnt(frame_cnt_b), .busy(busy_b), .state_dbg(state_dbg_b)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   function automatic logic [38:0] ev(input logic [1:0] kind, input logic [2:0] a,
                                      input logic [17:0] d, input int c);
      return {kind, a, d, c[15:0]};
   endfunction

   task automatic reset_model();
      exp_qa.delete();
      exp_qb.delete();
      cnt_m[0]  = 8'd0;
      cnt_m[1]  = 8'd0;
      done_m[0] = 1'b0;
      done_m[1] = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1; en = 1'b1; sen = 1'b1; sd = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain();
      repeat (4) begin @(posedge clk); #1; end
   endtask

   // ---------------- reference model (frame level) ----------------
   task automatic model_frame(input int n, input logic [31:0] val, input int ec);
      logic [2:0]  a;
      logic [17:0] d;
      logic [38:0] e;
      int depth, last;
      a = val[20:18];
      d = val[17:0];
      for (int k = 0; k < 2; k++) begin
         depth = (k == 0) ? 8 : 5;
         last  = (k == 0) ? 7 : 4;
         if (n != 21)                e = ev(2'd1, 3'd0, 18'd0, ec);
         else if (int'(a) >= depth)  e = ev(2'd2, 3'd0, 18'd0, ec);
         else                        e = ev(2'd0, a, d, ec);
         if (k == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
         if (n == 21 && int'(a) < depth) begin
            cnt_m[k] = cnt_m[k] + 8'd1;
            if (int'(a) == last && !done_m[k]) begin
               done_m[k] = 1'b1;
               e = ev(2'd3, 3'd0, 18'd0, ec + 1);
               if (k == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic send_frame(input int n, input logic [31:0] val, input int idle);
      for (int i = 0; i < n; i++) begin
         sen = 1'b0;
         sd  = val[n-1-i];
         @(posedge clk); #1;
      end
      sen = 1'b1;
      sd  = 1'b0;
      model_frame(n, val, cyc + 1);
      repeat (idle) begin @(posedge clk); #1; end
   endtask

   // ---------------- scoreboard ----------------
   task automatic sb(input int k, input logic [38:0] o);
      logic [38:0] e;
      if (k == 0 && exp_qa.size() > 0)      e = exp_qa.pop_front();
      else if (k == 1 && exp_qb.size() > 0) e = exp_qb.pop_front();
      else                                  e = '1;
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL sb_event dut%0d got=%h exp=%h (all-ones exp = none expected)", k, o, e);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         pd_a = 1'b0;
         pd_b = 1'b0;
      end else begin
         if (wr_en_a)        sb(0, ev(2'd0, wr_addr_a, wr_data_a, cyc));
         if (frame_err_a)    sb(0, ev(2'd1, 3'd0, 18'd0, cyc));
         if (addr_err_a)     sb(0, ev(2'd2, 3'd0, 18'd0, cyc));
         if (done_a && !pd_a) sb(0, ev(2'd3, 3'd0, 18'd0, cyc));
         if (wr_en_b)        sb(1, ev(2'd0, wr_addr_b, wr_data_b, cyc));
         if (frame_err_b)    sb(1, ev(2'd1, 3'd0, 18'd0, cyc));
         if (addr_err_b)     sb(1, ev(2'd2, 3'd0, 18'd0, cyc));
         if (done_b && !pd_b) sb(1, ev(2'd3, 3'd0, 18'd0, cyc));
         pd_a = done_a;
         pd_b = done_b;
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; en = 1'b1; sen = 1'b0; sd = 1'b1;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({wr_en_a, done_a, frame_err_a, addr_err_a, busy_a, frame_cnt_a, wr_addr_a, wr_data_a} !== 34'd0) begin
         bad++;
         $display("FAIL reset_a got=%b%b%b%b%b cnt=%h addr=%h data=%h exp=all zero",
                  wr_en_a, done_a, frame_err_a, addr_err_a, busy_a, frame_cnt_a, wr_addr_a, wr_data_a);
      end
      total++;
      if ({wr_en_b, done_b, frame_err_b, addr_err_b, busy_b, frame_cnt_b, wr_addr_b, wr_data_b} !== 34'd0) begin
         bad++;
         $display("FAIL reset_b got=%b%b%b%b%b cnt=%h exp=all zero",
                  wr_en_b, done_b, frame_err_b, addr_err_b, busy_b, frame_cnt_b);
      end
      // release with sen still low: the short frame must end as frame_err
      rst = 1'b0;
      send_frame(7, 32'h55, 1);
      drain();
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL reset_sen_low pending=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
      total++;
      if (frame_cnt_a !== 8'd0) begin
         bad++;
         $display("FAIL reset_sen_low_cnt got=%0d exp=0", frame_cnt_a);
      end
   endtask

   task automatic test_basic();
      apply_reset();
      send_frame(21, {11'd0, 3'd3, 18'h2A5C3}, 1);
      drain();
      total++;
      if (wr_addr_a !== 3'd3 || wr_data_a !== 18'h2A5C3) begin
         bad++;
         $display("FAIL basic_hold got=%h/%h exp=3/2a5c3", wr_addr_a, wr_data_a);
      end
      total++;
      if (frame_cnt_a !== 8'd1 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL basic_cnt_done got=%0d/%b exp=1/0", frame_cnt_a, done_a);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL basic_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_bad_len();
      apply_reset();
      send_frame(20, $urandom, 1);
      send_frame(22, $urandom, 1);
      drain();
      total++;
      if (frame_cnt_a !== 8'd0 || frame_cnt_b !== 8'd0) begin
         bad++;
         $display("FAIL badlen_cnt got=%0d/%0d exp=0/0", frame_cnt_a, frame_cnt_b);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL badlen_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_addr_range();
      logic [17:0] d;
      apply_reset();
      d = 18'($urandom);
      send_frame(21, {11'd0, 3'd6, d}, 1);
      d = 18'($urandom);
      send_frame(21, {11'd0, 3'd4, d}, 1);
      drain();
      total++;
      if (frame_cnt_a !== 8'd2 || frame_cnt_b !== 8'd1) begin
         bad++;
         $display("FAIL addr_cnt got=%0d/%0d exp=2/1", frame_cnt_a, frame_cnt_b);
      end
      total++;
      if (done_b !== 1'b1 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL addr_done got=%b/%b exp=0/1", done_a, done_b);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL addr_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int a = 0; a < 8; a++)
         send_frame(21, {11'd0, 3'(a), 18'($urandom)}, 1);
      drain();
      total++;
      if (frame_cnt_a !== 8'd8 || done_a !== 1'b1) begin
         bad++;
         $display("FAIL b2b_a got cnt=%0d done=%b exp=8/1", frame_cnt_a, done_a);
      end
      total++;
      if (frame_cnt_b !== 8'd5 || done_b !== 1'b1) begin
         bad++;
         $display("FAIL b2b_b got cnt=%0d done=%b exp=5/1", frame_cnt_b, done_b);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL b2b_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_enable();
      logic [31:0] v;
      apply_reset();
      v = $urandom;
      for (int i = 0; i < 21; i++) begin
         if (i == 10) begin
            total++;
            if (busy_a !== 1'b1) begin
               bad++;
               $display("FAIL en_busy got=%b exp=1", busy_a);
            end
            en = 1'b0;
         end
         sen = 1'b0; sd = v[20-i];
         @(posedge clk); #1;
      end
      sen = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      total++;
      if (busy_a !== 1'b0) begin
         bad++;
         $display("FAIL en_idle_busy got=%b exp=0", busy_a);
      end
      en = 1'b1;
      @(posedge clk); #1;
      send_frame(21, {11'd0, 3'd2, 18'($urandom)}, 1);
      // re-enable in the middle of a frame: only the enabled bits count
      en = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i == 5) en = 1'b1;
         sen = 1'b0; sd = 1'($urandom);
         @(posedge clk); #1;
      end
      sen = 1'b1;
      model_frame(12, 32'd0, cyc + 1);
      drain();
      total++;
      if (frame_cnt_a !== 8'd1 || frame_cnt_b !== 8'd1) begin
         bad++;
         $display("FAIL en_cnt got=%0d/%0d exp=1/1", frame_cnt_a, frame_cnt_b);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL en_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      send_frame(21, {11'd0, 3'd7, 18'($urandom)}, 1);
      drain();
      total++;
      if (done_a !== 1'b1) begin
         bad++;
         $display("FAIL rmid_done_before got=%b exp=1", done_a);
      end
      rst = 1'b1;
      reset_model();
      #1;
      total++;
      if ({wr_en_a, done_a, frame_err_a, addr_err_a, busy_a, frame_cnt_a, wr_addr_a, wr_data_a} !== 34'd0) begin
         bad++;
         $display("FAIL rmid_after_done got done=%b cnt=%0d addr=%h data=%h exp=all zero",
                  done_a, frame_cnt_a, wr_addr_a, wr_data_a);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         sen = 1'b0; sd = 1'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      reset_model();
      #1;
      total++;
      if ({busy_a, frame_cnt_a, busy_b, frame_cnt_b} !== 18'd0) begin
         bad++;
         $display("FAIL rmid_partial got busy=%b/%b cnt=%0d/%0d exp=0", busy_a, busy_b, frame_cnt_a, frame_cnt_b);
      end
      sen = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      send_frame(21, {11'd0, 3'd1, 18'($urandom)}, 1);
      drain();
      total++;
      if (frame_cnt_a !== 8'd1 || frame_cnt_b !== 8'd1 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL rmid_next got cnt=%0d/%0d done=%b exp=1/1/0", frame_cnt_a, frame_cnt_b, done_a);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL rmid_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   task automatic test_random();
      int n;
      apply_reset();
      for (int f = 0; f < 40; f++) begin
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 24) : 21;
         send_frame(n, $urandom, $urandom_range(1, 3));
      end
      drain();
      total++;
      if (frame_cnt_a !== cnt_m[0] || frame_cnt_b !== cnt_m[1]) begin
         bad++;
         $display("FAIL rand_cnt got=%0d/%0d exp=%0d/%0d", frame_cnt_a, frame_cnt_b, cnt_m[0], cnt_m[1]);
      end
      total++;
      if (done_a !== done_m[0] || done_b !== done_m[1]) begin
         bad++;
         $display("FAIL rand_done got=%b/%b exp=%b/%b", done_a, done_b, done_m[0], done_m[1]);
      end
      total++;
      if (exp_qa.size() + exp_qb.size() != 0) begin
         bad++;
         $display("FAIL rand_pending got=%0d exp=0", exp_qa.size() + exp_qb.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1'b1; en = 1'b1; sen = 1'b1; sd = 1'b0;
      test_reset();
      test_basic();
      test_bad_len();
      test_addr_range();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
